// File: rtl/tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// tick_scheduler_if
//
// Purpose: command port of the tick scheduler. It carries one valid/ready
// transfer per command and a one-cycle reject pulse for refused commands.
//
// Signals:
//   cfg_valid   master -> slave   command valid
//   cfg_ready   slave  -> master  command accept (transfer on valid && ready)
//   cfg_ch      master -> slave   target channel index
//   cfg_op      master -> slave   00 stop, 01 one-shot, 10 periodic, 11 reserved
//   cfg_period  master -> slave   period in ticks
//   cfg_err     slave  -> master  one-cycle pulse after a rejected command
// ---------------------------------------------------------------------------
interface tick_scheduler_if #(
    parameter int PW = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_ch;
    logic [1:0]    cfg_op;
    logic [PW-1:0] cfg_period;
    logic          cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_op,
        output cfg_period,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_op,
        input  cfg_period,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/tick_scheduler.sv
// ---------------------------------------------------------------------------
// tick_scheduler
//
// Purpose: multi-channel millisecond timer scheduler. A single prescaler
// divides clk_in into a TICK_HZ clock-enable strobe. NUM_CH independent
// channels count that strobe and emit one-cycle expiry pulses in one-shot
// or periodic mode.
//
// Ports:
//   clk_in     system clock
//   rst_n      asynchronous, active-low reset
//   en         global run enable; low freezes prescaler and channels
//   cfg        command port (slave side of tick_scheduler_if)
//   tick_1ms   registered one-cycle tick strobe
//   ch_pulse   registered one-cycle expiry pulse per channel
//   ch_active  registered channel-running flag per channel
// ---------------------------------------------------------------------------
module tick_scheduler #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1000,
    parameter int NUM_CH  = 4,
    parameter int PW      = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    tick_scheduler_if.slave   cfg,
    output logic              tick_1ms,
    output logic [NUM_CH-1:0] ch_pulse,
    output logic [NUM_CH-1:0] ch_active
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [3:0]    NUM_CH_L = 4'(NUM_CH);

    localparam logic [1:0] OP_STOP     = 2'b00;
    localparam logic [1:0] OP_ONESHOT  = 2'b01;
    localparam logic [1:0] OP_PERIODIC = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_ONESHOT  = 2'd1,
        CH_PERIODIC = 2'd2
    } ch_state_t;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_s;
    logic              tick_q, tick_d;
    logic              cfg_ready_s;
    logic              accept;
    logic              cmd_bad;
    logic              cmd_ok;
    logic              is_start;
    logic              err_q, err_d;
    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [PW-1:0]     rem_q   [NUM_CH];
    logic [PW-1:0]     rem_d   [NUM_CH];
    logic [PW-1:0]     per_q   [NUM_CH];
    logic [PW-1:0]     per_d   [NUM_CH];
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] active_q, active_d;

    // Prescaler: counts enabled cycles 0..DIV-1; tick_s is the enable strobe.
    always_comb begin
        tick_s = en && (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        if (en) begin
            cnt_d = tick_s ? '0 : cnt_q + 1'b1;
        end
        tick_d = tick_s;
    end

    // Commands are refused on tick cycles so a channel never sees a tick and
    // a command in the same cycle.
    assign cfg_ready_s = rst_n && !tick_s;

    always_comb begin
        accept   = cfg.cfg_valid && cfg_ready_s;
        is_start = (cfg.cfg_op == OP_ONESHOT) || (cfg.cfg_op == OP_PERIODIC);
        cmd_bad  = ({1'b0, cfg.cfg_ch} >= NUM_CH_L) ||
                   (cfg.cfg_op == OP_RSVD) ||
                   (is_start && (cfg.cfg_period == '0));
        err_d    = accept && cmd_bad;
        cmd_ok   = accept && !cmd_bad;
    end

    // Per-channel next state. Tick and command branches are mutually
    // exclusive because accept implies !tick_s.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            per_d[i]   = per_q[i];
            pulse_d[i] = 1'b0;
            if (tick_s && (state_q[i] != CH_IDLE)) begin
                if (rem_q[i] == PW'(1)) begin
                    pulse_d[i] = 1'b1;
                    if (state_q[i] == CH_PERIODIC) begin
                        rem_d[i] = per_q[i];
                    end else begin
                        state_d[i] = CH_IDLE;
                    end
                end else if (rem_q[i] > PW'(1)) begin
                    rem_d[i] = rem_q[i] - 1'b1;
                end
            end else if (cmd_ok && (cfg.cfg_ch == 3'(i))) begin
                unique case (cfg.cfg_op)
                    OP_STOP: begin
                        state_d[i] = CH_IDLE;
                    end
                    OP_ONESHOT: begin
                        state_d[i] = CH_ONESHOT;
                        rem_d[i]   = cfg.cfg_period;
                        per_d[i]   = cfg.cfg_period;
                    end
                    OP_PERIODIC: begin
                        state_d[i] = CH_PERIODIC;
                        rem_d[i]   = cfg.cfg_period;
                        per_d[i]   = cfg.cfg_period;
                    end
                    default: begin
                    end
                endcase
            end
            active_d[i] = (state_d[i] != CH_IDLE);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
            pulse_q  <= '0;
            active_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                rem_q[i]   <= '0;
                per_q[i]   <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                per_q[i]   <= per_d[i];
            end
        end
    end

    assign cfg.cfg_ready = cfg_ready_s;
    assign cfg.cfg_err   = err_q;
    assign tick_1ms      = tick_q;
    assign ch_pulse      = pulse_q;
    assign ch_active     = active_q;

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel millisecond timer scheduler built on a single shared prescaler.
- Divides clk_in down to a 1 kHz tick strobe. The strobe is a clock-enable, never a derived clock.
- Shares that tick among NUM_CH independent channels. Each channel is configured through a valid/ready command port and emits one-cycle expiry pulses in one-shot or periodic mode.
- Sits between the system clock and the display/debounce/timing blocks that need ms-scale events.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1000, tick strobe frequency. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
- NUM_CH, 4, number of timer channels (1..8).
- PW, 16, channel period width in ticks.

Ports:
- clk_in  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global run enable; 0 freezes prescaler and all channels
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accept; a transfer occurs when cfg_valid && cfg_ready
- cfg_ch  in  3  target channel index
- cfg_op  in  2  00 stop, 01 start one-shot, 10 start periodic, 11 reserved
- cfg_period  in  PW  period in ticks
- cfg_err  out  1  one-cycle pulse when an accepted command is rejected
- tick_1ms  out  1  one-cycle tick strobe
- ch_pulse  out  NUM_CH  one-cycle expiry pulse per channel
- ch_active  out  NUM_CH  channel running flag

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0; all channels IDLE with rem = 0.
  - tick_1ms, ch_pulse, ch_active, cfg_err = 0; cfg_ready = 0 while rst_n is low.
- Prescaler:
  - Counter is sized to hold DIV-1 (clog2(DIV) bits, >= 17 bits at defaults). Undersizing is a defect.
  - When en = 1, it counts 0..DIV-1 and wraps to 0.
  - Internal strobe: tick_s = en && (cnt == DIV-1).
  - tick_1ms is registered: it is high for exactly one cycle following each tick_s, giving period = DIV cycles.
  - When en = 0, the counter holds, tick_s = 0, channels hold state and rem, and commands are still accepted.
- Channel FSM (per channel): IDLE, ONESHOT, PERIODIC; registers rem[PW-1:0] and per[PW-1:0].
  - On tick_s, a non-IDLE channel with rem == 1 fires:
    - ch_pulse[i] is asserted registered, in the same cycle as tick_1ms.
    - PERIODIC: rem <= per.
    - ONESHOT: go to IDLE; ch_active[i] drops in the same cycle ch_pulse[i] rises.
  - On tick_s, a non-IDLE channel with rem > 1 decrements rem.
  - Multiple channels may fire in the same cycle.
  - First pulse occurs between (P-1)*DIV+1 and P*DIV+1 cycles after command accept, depending on prescaler phase.
- Command port:
  - cfg_ready = !tick_s, and 0 during reset. Ticks and commands therefore never update a channel in the same cycle.
  - The master must hold cfg_* stable while cfg_valid && !cfg_ready.
  - Accepted start with 1 <= P: per <= P, rem <= P, state <= ONESHOT or PERIODIC, ch_active[i] = 1 next cycle.
  - Start on an already-active channel restarts it: reload, mode change, no pulse.
  - Accepted stop: state <= IDLE, ch_active[i] = 0 next cycle, no pulse. Stop on an IDLE channel is a no-op with no error.
  - Rejected commands (no state change, cfg_err high one cycle after accept):
    - cfg_ch >= NUM_CH;
    - cfg_op == 11;
    - start with cfg_period == 0.
- Reset mid-operation: all outputs clear immediately. After release, the prescaler restarts from 0 and pending channel state is lost.
- Register outputs only; no combinational path from cfg_* to any output.

Test Plan:
- All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10) and NUM_CH=3.
- Release reset with en=1 and no commands -> tick_1ms high for 1 cycle every 10 cycles; first occurrence 10 cycles after release; ch_pulse stays 0.
- Start one-shot ch0 with P=3 -> ch_active[0]=1 next cycle; exactly one ch_pulse[0], coincident with the 3rd tick_1ms after accept; ch_active[0]=0 in that same cycle.
- Start periodic ch1 with P=2 and periodic ch2 with P=4 -> ch_pulse[1] every 20 cycles, ch_pulse[2] every 40 cycles, coinciding every 2nd ch1 pulse. Stop ch1 -> no further ch_pulse[1], ch_active[1]=0 one cycle after accept.
- Assert cfg_valid on the cycle where tick_s=1 -> cfg_ready=0 that cycle; command accepted the next cycle; exactly one accept.
- Send cfg_ch=3, then cfg_op=11, then start with P=0 -> three cfg_err pulses; ch_active unchanged.
- Run periodic ch0 with P=5, pull en low for 25 cycles, then restore -> no ticks or pulses while en=0, pulse spacing resumes unchanged. Separately, assert rst_n low mid-count -> all outputs 0 asynchronously.
